cfg_stream_loader: RTL and testbench

- Reads the overlay configuration bitstream, byte by byte, out of the single-port on-chip configuration memory.
- Acts as the reading master on that memory's port. The memory has a registered address, unregistered output and a clock enable.
- Packs consecutive bytes into configuration words and streams them to the overlay configuration controller over a valid/ready handshake.
- One run per start pulse; reports completion.

---
 rtl/cfg_stream_loader.sv | 177 +++++++++++++++++
 tb/tb_cfg_stream_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: walks the configuration bitstream out of the single-port
// config memory (registered address, unregistered data, clock enable), packs
// bytes LSB-first into words and streams them over a valid/ready handshake.
// Optional build macro: CFG_STREAM_CHECKSUM_EN adds one trailer read after
// the last word and flags a nonzero mod-256 sum of bitstream plus trailer.
module cfg_stream_loader #(
  parameter int ADDR_WIDTH     = 17,
  parameter int BYTE_WIDTH     = 8,
  parameter int NUM_BYTES      = 100000,
  parameter int BYTES_PER_WORD = 4,
  parameter int START_ADDR     = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [ADDR_WIDTH-1:0]                mem_address,
  output logic                                 mem_chipselect,
  output logic                                 mem_clken,
  output logic                                 mem_write,
  output logic [BYTE_WIDTH-1:0]                mem_writedata,
  input  logic [BYTE_WIDTH-1:0]                mem_readdata,
  output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] cfg_data,
  output logic                                 cfg_valid,
  input  logic                                 cfg_ready,
  output logic                                 cfg_last,
  output logic                                 checksum_err
);

  // one extra pointer bit so START_ADDR+NUM_BYTES == 2^ADDR_WIDTH never wraps
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD + 1) : 1;
  localparam logic [PTR_W-1:0] BEGIN_PTR = PTR_W'(START_ADDR);
  localparam logic [PTR_W-1:0] END_PTR   = PTR_W'(START_ADDR + NUM_BYTES);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(START_ADDR + NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] FULL_IDX  = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CAPT, S_EMIT, S_TADDR, S_TCAPT
  } state_t;

  state_t                                   state_q, state_d;
  logic [PTR_W-1:0]                         ptr_q, ptr_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0] buf_q, buf_d;
  logic                                     done_q, done_d;
`ifdef CFG_STREAM_CHECKSUM_EN
  logic [7:0]                               sum_q, sum_d;
  logic                                     err_q, err_d;
`endif

  // state and datapath registers; reset abandons any load without a done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
`ifdef CFG_STREAM_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
`ifdef CFG_STREAM_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  // next-state, byte packing and memory/stream strobes
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    idx_d          = idx_q;
    buf_d          = buf_q;
    done_d         = 1'b0;
`ifdef CFG_STREAM_CHECKSUM_EN
    sum_d          = sum_q;
    err_d          = err_q;
`endif
    mem_chipselect = 1'b0;
    mem_clken      = 1'b0;
    mem_address    = '0;
    cfg_valid      = 1'b0;
    cfg_last       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q high means we are in the done cycle: start there is ignored
        if (start && !done_q) begin
          state_d = S_ADDR;
          ptr_d   = BEGIN_PTR;
          idx_d   = '0;
          buf_d   = '0;
`ifdef CFG_STREAM_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        mem_chipselect = 1'b1;
        mem_clken      = 1'b1;
        mem_address    = ptr_q[ADDR_WIDTH-1:0];
        state_d        = S_CAPT;
      end
      S_CAPT: begin
        // clken low keeps the registered address, so readdata is stable here
        mem_chipselect = 1'b1;
        mem_address    = ptr_q[ADDR_WIDTH-1:0];
        for (int l = 0; l < BYTES_PER_WORD; l++)
          if (idx_q == IDX_W'(l)) buf_d[l] = mem_readdata;
`ifdef CFG_STREAM_CHECKSUM_EN
        sum_d = sum_q + 8'(mem_readdata);
`endif
        ptr_d = ptr_q + 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == FULL_IDX || ptr_q == LAST_PTR) state_d = S_EMIT;
        else                                        state_d = S_ADDR;
      end
      S_EMIT: begin
        cfg_valid = 1'b1;
        cfg_last  = (ptr_q == END_PTR);
        if (cfg_ready) begin
          buf_d = '0;
          idx_d = '0;
          if (ptr_q != END_PTR) begin
            state_d = S_ADDR;
          end else begin
`ifdef CFG_STREAM_CHECKSUM_EN
            state_d = S_TADDR;
`else
            done_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef CFG_STREAM_CHECKSUM_EN
      S_TADDR: begin
        // pointer already sits on START_ADDR+NUM_BYTES, the trailer byte
        mem_chipselect = 1'b1;
        mem_clken      = 1'b1;
        mem_address    = ptr_q[ADDR_WIDTH-1:0];
        state_d        = S_TCAPT;
      end
      S_TCAPT: begin
        mem_chipselect = 1'b1;
        mem_address    = ptr_q[ADDR_WIDTH-1:0];
        err_d          = ((sum_q + 8'(mem_readdata)) != 8'd0);
        done_d         = 1'b1;
        state_d        = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign cfg_data      = buf_q;
  assign mem_write     = 1'b0;
  assign mem_writedata = '0;
`ifdef CFG_STREAM_CHECKSUM_EN
  assign checksum_err  = err_q;
`else
  assign checksum_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: three instances (8-byte, 6-byte and
// 4-byte bitstreams, 4 bytes per word) each backed by a small memory model
// with registered address and combinational read data.
module tb_cfg_stream_loader;

`ifdef CFG_STREAM_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_ab [0:15];
  logic [7:0] mem_c  [0:15];

  // instance A: 8 bytes
  logic a_start = 0, a_ready = 1;
  logic a_busy, a_done, a_cs, a_clken, a_wr, a_valid, a_last, a_err;
  logic [16:0] a_addr, a_ra = '0;
  logic [7:0] a_wdata, a_rdata;
  logic [31:0] a_data;
  // instance B: 6 bytes
  logic b_start = 0, b_ready = 1;
  logic b_busy, b_done, b_cs, b_clken, b_wr, b_valid, b_last, b_err;
  logic [16:0] b_addr, b_ra = '0;
  logic [7:0] b_wdata, b_rdata;
  logic [31:0] b_data;
  // instance C: 4 bytes plus optional trailer
  logic c_start = 0, c_ready = 1;
  logic c_busy, c_done, c_cs, c_clken, c_wr, c_valid, c_last, c_err;
  logic [16:0] c_addr, c_ra = '0;
  logic [7:0] c_wdata, c_rdata;
  logic [31:0] c_data;

  cfg_stream_loader #(.ADDR_WIDTH(17), .BYTE_WIDTH(8), .NUM_BYTES(8),
    .BYTES_PER_WORD(4), .START_ADDR(0)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
    .mem_address(a_addr), .mem_chipselect(a_cs), .mem_clken(a_clken),
    .mem_write(a_wr), .mem_writedata(a_wdata), .mem_readdata(a_rdata),
    .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready),
    .cfg_last(a_last), .checksum_err(a_err));

  cfg_stream_loader #(.ADDR_WIDTH(17), .BYTE_WIDTH(8), .NUM_BYTES(6),
    .BYTES_PER_WORD(4), .START_ADDR(0)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_address(b_addr), .mem_chipselect(b_cs), .mem_clken(b_clken),
    .mem_write(b_wr), .mem_writedata(b_wdata), .mem_readdata(b_rdata),
    .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .cfg_last(b_last), .checksum_err(b_err));

  cfg_stream_loader #(.ADDR_WIDTH(17), .BYTE_WIDTH(8), .NUM_BYTES(4),
    .BYTES_PER_WORD(4), .START_ADDR(0)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .busy(c_busy), .done(c_done),
    .mem_address(c_addr), .mem_chipselect(c_cs), .mem_clken(c_clken),
    .mem_write(c_wr), .mem_writedata(c_wdata), .mem_readdata(c_rdata),
    .cfg_data(c_data), .cfg_valid(c_valid), .cfg_ready(c_ready),
    .cfg_last(c_last), .checksum_err(c_err));

  // memory models: address registers on clken, data is combinational
  always @(posedge clk) begin
    if (a_cs && a_clken) a_ra <= a_addr;
    if (b_cs && b_clken) b_ra <= b_addr;
    if (c_cs && c_clken) c_ra <= c_addr;
  end
  assign a_rdata = mem_ab[a_ra[3:0]];
  assign b_rdata = mem_ab[b_ra[3:0]];
  assign c_rdata = mem_c[c_ra[3:0]];

  // transaction logs
  logic [31:0] a_words[$], b_words[$], c_words[$];
  bit          a_lasts[$], b_lasts[$], c_lasts[$];
  int          a_addrs[$], c_addrs[$];
  int          a_done_cnt = 0, b_done_cnt = 0, c_done_cnt = 0;

  always @(posedge clk) begin
    if (a_valid && a_ready) begin a_words.push_back(a_data); a_lasts.push_back(a_last); end
    if (b_valid && b_ready) begin b_words.push_back(b_data); b_lasts.push_back(b_last); end
    if (c_valid && c_ready) begin c_words.push_back(c_data); c_lasts.push_back(c_last); end
    if (a_cs && a_clken) a_addrs.push_back(int'(a_addr));
    if (c_cs && c_clken) c_addrs.push_back(int'(c_addr));
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if (c_done) c_done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    a_words.delete(); a_lasts.delete(); a_addrs.delete();
    b_words.delete(); b_lasts.delete();
    c_words.delete(); c_lasts.delete(); c_addrs.delete();
    a_done_cnt = 0; b_done_cnt = 0; c_done_cnt = 0;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    reset = 1'b1;
    repeat (3) tick();
    outs = {a_busy, a_done, a_addr, a_cs, a_clken, a_wr, a_valid, a_last, a_err, a_wdata, a_data};
    checks++;
    if (outs !== 64'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: busy=%b valid=%b want 0 0", a_busy, a_valid);
    end
  endtask

  task automatic test_basic();
    int n;
    clear_logs();
    a_ready = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", a_busy); end
    repeat (7) tick();
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b want 0 at cycle 8", a_valid); end
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 32'h04030201 || a_last !== 1'b0) begin
      errors++; $display("FAIL basic_first_word: valid=%b data=%h last=%b want 1 04030201 0", a_valid, a_data, a_last);
    end
    n = 0;
    while (!a_done && n < 100) begin tick(); n++; end
    checks++;
    if (!a_done) begin errors++; $display("FAIL basic_done_timeout: done never seen, want 1"); end
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", a_busy); end
    repeat (5) tick();
    checks++;
    if (a_words.size() != 2) begin
      errors++; $display("FAIL basic_word_count: got %0d want 2", a_words.size());
    end else if (a_words[1] !== 32'h08070605 || a_lasts[0] !== 1'b0 || a_lasts[1] !== 1'b1) begin
      errors++; $display("FAIL basic_second_word: data=%h lasts=%b%b want 08070605 last 0,1", a_words[1], a_lasts[0], a_lasts[1]);
    end
    checks++;
    if (a_done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", a_done_cnt); end
  endtask

  task automatic test_partial();
    int n;
    clear_logs();
    b_start = 1'b1; tick(); b_start = 1'b0;
    n = 0;
    while (!b_done && n < 100) begin tick(); n++; end
    checks++;
    if (!b_done) begin errors++; $display("FAIL partial_done_timeout: done never seen, want 1"); end
    repeat (5) tick();
    checks++;
    if (b_words.size() != 2) begin
      errors++; $display("FAIL partial_word_count: got %0d want 2", b_words.size());
    end else if (b_words[0] !== 32'h04030201 || b_words[1] !== 32'h00000605 ||
                 b_lasts[0] !== 1'b0 || b_lasts[1] !== 1'b1) begin
      errors++; $display("FAIL partial_words: w0=%h w1=%h lasts=%b%b want 04030201 00000605 0,1",
                         b_words[0], b_words[1], b_lasts[0], b_lasts[1]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit stable;
    logic [31:0] held;
    clear_logs();
    a_ready = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    n = 0;
    while (!a_valid && n < 50) begin tick(); n++; end
    held = a_data;
    checks++;
    if (held !== 32'h04030201) begin errors++; $display("FAIL bp_first_word: got %h want 04030201", held); end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_valid !== 1'b1 || a_data !== held || a_clken !== 1'b0 || a_last !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_stall_stable: got unstable valid/data/clken want held for 20 cycles"); end
    checks++;
    if (a_addrs.size() != 4) begin errors++; $display("FAIL bp_no_reads_stalled: got %0d reads want 4", a_addrs.size()); end
    a_ready = 1'b1;
    n = 0;
    while (!a_done && n < 100) begin tick(); n++; end
    repeat (5) tick();
    checks++;
    if (a_words.size() != 2 || a_done_cnt != 1) begin
      errors++; $display("FAIL bp_word_count: got %0d words %0d done want 2 words 1 done", a_words.size(), a_done_cnt);
    end
  endtask

  task automatic test_reset_midload();
    int n;
    clear_logs();
    a_ready = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (7) tick();
    // now in the capture cycle of the fourth byte
    checks++;
    if (a_cs !== 1'b1 || a_clken !== 1'b0 || a_addr !== 17'd3) begin
      errors++; $display("FAIL rst_mid_in_capt: cs=%b clken=%b addr=%0d want 1 0 3", a_cs, a_clken, a_addr);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({a_busy, a_done, a_cs, a_clken, a_valid, a_last} !== 6'b0 || a_data !== 32'd0 || a_addr !== 17'd0) begin
      errors++; $display("FAIL rst_mid_outputs: busy=%b cs=%b valid=%b data=%h addr=%0d want all 0",
                         a_busy, a_cs, a_valid, a_data, a_addr);
    end
    repeat (20) tick();
    checks++;
    if (a_done_cnt != 0 || a_words.size() != 0) begin
      errors++; $display("FAIL rst_mid_no_done: got done=%0d words=%0d want 0 0", a_done_cnt, a_words.size());
    end
    clear_logs();
    a_start = 1'b1; tick(); a_start = 1'b0;
    n = 0;
    while (!a_done && n < 100) begin tick(); n++; end
    repeat (3) tick();
    checks++;
    if (a_words.size() != 2 || a_addrs.size() == 0) begin
      errors++; $display("FAIL rst_mid_reload_count: got %0d words want 2", a_words.size());
    end else if (a_words[0] !== 32'h04030201 || a_addrs[0] != 0) begin
      errors++; $display("FAIL rst_mid_reload_word: got %h addr0=%0d want 04030201 addr0=0", a_words[0], a_addrs[0]);
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    bit seq_ok;
    clear_logs();
    a_ready = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (4) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    n = 0;
    while (!a_valid && n < 50) begin tick(); n++; end
    a_start = 1'b1; tick(); a_start = 1'b0;
    n = 0;
    while (!a_done && n < 100) begin tick(); n++; end
    checks++;
    if (!a_done) begin errors++; $display("FAIL busy_done_timeout: done never seen, want 1"); end
    // start in the done cycle must not relaunch
    a_start = 1'b1; tick(); a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_start_at_done: busy=%b want 0", a_busy); end
    repeat (20) tick();
    seq_ok = (a_addrs.size() == 8 + CHK);
    foreach (a_addrs[i]) if (a_addrs[i] != i) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin errors++; $display("FAIL busy_addresses: got %0d reads want %0d sequential from 0", a_addrs.size(), 8 + CHK); end
    checks++;
    if (a_words.size() != 2 || a_done_cnt != 1) begin
      errors++; $display("FAIL busy_counts: got %0d words %0d done want 2 1", a_words.size(), a_done_cnt);
    end
  endtask

  task automatic run_c(output bit err_at_done);
    int n;
    clear_logs();
    c_start = 1'b1; tick(); c_start = 1'b0;
    n = 0;
    while (!c_done && n < 100) begin tick(); n++; end
    checks++;
    if (!c_done) begin errors++; $display("FAIL chk_done_timeout: done never seen, want 1"); end
    err_at_done = c_err;
  endtask

  task automatic test_checksum();
    bit e;
    mem_c[4] = 8'h60;
    run_c(e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL chk_good_trailer: err=%b want 0", e); end
    checks++;
    if (c_words.size() != 1 || c_words[0] !== 32'h40302010 || c_lasts[0] !== 1'b1) begin
      errors++; $display("FAIL chk_word: got %0d words want one 40302010 last", c_words.size());
    end
    tick();
    mem_c[4] = 8'h61;
    run_c(e);
    repeat (5) tick();
`ifdef CFG_STREAM_CHECKSUM_EN
    checks++;
    if (e !== 1'b1 || c_err !== 1'b1) begin
      errors++; $display("FAIL chk_bad_trailer: err=%b held=%b want 1 1", e, c_err);
    end
    checks++;
    if (c_addrs.size() != 5 || c_addrs[4] != 4) begin
      errors++; $display("FAIL chk_trailer_read: got %0d reads want 5 ending at 4", c_addrs.size());
    end
    c_start = 1'b1; tick(); c_start = 1'b0;
    checks++;
    if (c_err !== 1'b0) begin errors++; $display("FAIL chk_clear_on_start: err=%b want 0", c_err); end
    repeat (30) tick();
`else
    checks++;
    if (e !== 1'b0 || c_err !== 1'b0) begin
      errors++; $display("FAIL chk_disabled_err: err=%b want 0", e);
    end
    checks++;
    if (c_addrs.size() != 4) begin
      errors++; $display("FAIL chk_no_trailer_read: got %0d reads want 4", c_addrs.size());
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_ab[i] = 8'(i + 1);
      mem_c[i]  = 8'h00;
    end
    mem_c[0] = 8'h10; mem_c[1] = 8'h20; mem_c[2] = 8'h30; mem_c[3] = 8'h40;
    test_reset();
    repeat (2) tick();
    test_basic();
    repeat (2) tick();
    test_partial();
    repeat (2) tick();
    test_backpressure();
    repeat (2) tick();
    test_reset_midload();
    repeat (2) tick();
    test_start_while_busy();
    repeat (2) tick();
    test_checksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
